// File: rtl/cello_tt_pkg.sv
// rtl/cello_tt_pkg.sv - shared types and helpers for the truth-table sweeper
package cello_tt_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} tt_state_e;

  function automatic int ROWS_OF(input int n);
    return 2 ** n;
  endfunction

  // Row 0 lands in the MSB of the code, so the hex code reads like a truth table top-down.
  function automatic int row_bit_idx(input int rows, input int r);
    return rows - 1 - r;
  endfunction

endpackage

// File: rtl/tt_cycle_counter.sv
// rtl/tt_cycle_counter.sv - loadable down-counter with zero flag, shared by settle and sample windows
module tt_cycle_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - drives every gate input row, samples the output and assembles the truth-table code
module truth_table_sweeper
  import cello_tt_pkg::*;
#(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_CYCLES = 2,
  localparam int ROWS         = ROWS_OF(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ROWS-1:0] expected_code,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [ROWS-1:0] code,
  output logic            match,
  output logic            unstable
);

  localparam int MAX_CYC = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  tt_state_e       r_state, w_state_next;
  logic [N_IN-1:0] r_row;
  logic [ROWS-1:0] r_expected, r_shift, r_code, w_shift_final;
  logic            r_sticky, r_first, r_have_first, r_match, r_unstable;
  logic            w_sticky_final, w_last_row, w_cnt_load, w_cnt_zero, w_busy;
  logic [CW-1:0]   w_cnt_load_val;
  logic [N_IN-1:0] w_bit_idx;

  assign w_busy     = (r_state == SETTLE) || (r_state == SAMPLE);
  assign w_last_row = (r_row == N_IN'(ROWS - 1));
  assign w_bit_idx  = N_IN'(row_bit_idx(ROWS, int'(r_row)));

  tt_cycle_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_busy),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SETTLE;
      SETTLE:  if (w_cnt_zero) w_state_next = SAMPLE;
      SAMPLE:  if (w_cnt_zero) w_state_next = w_last_row ? DONE : SETTLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    dut_in = w_busy ? r_row : '0;
    busy   = w_busy;
    done   = (r_state == DONE);
  end

  // Loading one less than the window length gives exactly that many cycles before zero.
  always_comb begin
    w_cnt_load     = 1'b0;
    w_cnt_load_val = CW'(SETTLE_CYCLES - 1);
    case (r_state)
      IDLE:   w_cnt_load = start;
      SETTLE: if (w_cnt_zero) begin
                w_cnt_load     = 1'b1;
                w_cnt_load_val = CW'(SAMPLE_CYCLES - 1);
              end
      SAMPLE: w_cnt_load = w_cnt_zero && !w_last_row;
      default: ;
    endcase
  end

  always_comb begin
    w_shift_final            = r_shift;
    w_shift_final[w_bit_idx] = dut_out;
    w_sticky_final           = r_sticky | (r_have_first & (dut_out != r_first));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row        <= '0;
      r_expected   <= '0;
      r_shift      <= '0;
      r_code       <= '0;
      r_sticky     <= 1'b0;
      r_first      <= 1'b0;
      r_have_first <= 1'b0;
      r_match      <= 1'b0;
      r_unstable   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_expected   <= expected_code;
          r_row        <= '0;
          r_shift      <= '0;
          r_sticky     <= 1'b0;
          r_have_first <= 1'b0;
        end
        SAMPLE: begin
          r_sticky <= w_sticky_final;
          if (!r_have_first) begin
            r_first      <= dut_out;
            r_have_first <= 1'b1;
          end
          if (w_cnt_zero) begin
            r_shift      <= w_shift_final;
            r_have_first <= 1'b0;
            if (!w_last_row) begin
              r_row <= r_row + 1'b1;
            end else begin
              // Results only move here so they stay frozen for the whole next sweep.
              r_code     <= w_shift_final;
              r_unstable <= w_sticky_final;
              r_match    <= (w_shift_final == r_expected) && !w_sticky_final;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign code     = r_code;
  assign match    = r_match;
  assign unstable = r_unstable;

endmodule
